addsub_seq: RTL and testbench

Parametrised multi-cycle two's-complement adder/subtractor. Operands are latched on a start handshake and processed CHUNK bits per cycle through a ripple chunk adder, least-significant chunk first, with carry held in a register between cycles. It serves as the shared integer add/sub engine of the datapath, replacing fixed-width combinational subtractors, and reports carry and optional status flags.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_chunk.sv | 28 ++
 rtl/addsub_seq.sv | 140 ++++++++++++++
 tb/tb_addsub_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and encodings for the multi-cycle add/sub engine.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module addsub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
        cout = w_c[CHUNK];
        cmsb = w_c[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per cycle, LS chunk first.
// Status flags are built only when ADDSUB_FLAGS_EN is defined; otherwise tied to 0.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_next_result;

`ifdef ADDSUB_FLAGS_EN
    logic               w_cmsb;
`else
    logic               w_unused_cmsb;
`endif

    always_comb begin
        w_a_chunk     = CHUNK'(r_a >> (r_idx * CHUNK));
        w_b_chunk     = CHUNK'(r_b >> (r_idx * CHUNK));
        w_last        = (r_idx == IDX_W'(N - 1));
        w_next_result = r_result;
        w_next_result[r_idx * CHUNK +: CHUNK] = w_sum;
    end

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
`ifdef ADDSUB_FLAGS_EN
        .cmsb (w_cmsb)
`else
        .cmsb (w_unused_cmsb)
`endif
    );

    // Subtract is a + ~b + 1: operand B is inverted at latch time and the carry seeded with op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= (op == OP_SUB) ? ~b : b;
                        r_carry <= op;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_result <= w_next_result;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;
    logic r_flag_v;

    // Overflow as carry-into-MSB xor carry-out, equivalent to the operand/result sign test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_flag_z <= (w_next_result == '0);
            r_flag_n <= w_next_result[WIDTH-1];
            r_flag_v <= w_cmsb ^ w_cout;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_v = r_flag_v;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (16/4 and 8/8 configurations).
module tb_addsub_seq;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, flag_z, flag_n, flag_v;
    logic [15:0] result;

    logic        start8 = 1'b0;
    logic        op8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, cout8, fz8, fn8, fv8;
    logic [7:0]  result8;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8),
        .flag_z(fz8), .flag_n(fn8), .flag_v(fv8)
    );

    task automatic start16(input logic o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen; 0 means timeout.
    task automatic wait16(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0000", result); end
        n_checks++; if (cout !== 1'b0)    begin n_fail++; $display("FAIL reset_cout got %b exp 0", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {flag_z, flag_n, flag_v}); end
        n_checks++; if (result8 !== 8'h0) begin n_fail++; $display("FAIL reset_result8 got %h exp 00", result8); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int c;
        start16(1'b0, 16'h1234, 16'h0FFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got %b exp 1", busy); end
        wait16(c);
        n_checks++; if (c != 4)            begin n_fail++; $display("FAIL add_latency got %0d exp 4", c); end
        n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL add_result got %h exp 2233", result); end
        n_checks++; if (cout !== 1'b0)     begin n_fail++; $display("FAIL add_cout got %b exp 0", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL add_flags got %b exp 000", {flag_z, flag_n, flag_v}); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL add_done_pulse got %b exp 0", done); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL add_idle_busy got %b exp 0", busy); end
        n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL add_hold got %h exp 2233", result); end
    endtask

    task automatic test_sub;
        int c;
        start16(1'b1, 16'h0005, 16'h0007);
        wait16(c);
        n_checks++; if (c != 4)              begin n_fail++; $display("FAIL sub1_latency got %0d exp 4", c); end
        n_checks++; if (result !== 16'hFFFE) begin n_fail++; $display("FAIL sub1_result got %h exp fffe", result); end
        n_checks++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL sub1_cout got %b exp 0", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== {1'b0, FE, 1'b0}) begin n_fail++; $display("FAIL sub1_flags got %b exp %b", {flag_z, flag_n, flag_v}, {1'b0, FE, 1'b0}); end
        start16(1'b1, 16'h00A0, 16'h00A0);
        wait16(c);
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL sub2_result got %h exp 0000", result); end
        n_checks++; if (cout !== 1'b1)       begin n_fail++; $display("FAIL sub2_cout got %b exp 1", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== {FE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub2_flags got %b exp %b", {flag_z, flag_n, flag_v}, {FE, 1'b0, 1'b0}); end
    endtask

    task automatic test_overflow;
        int c;
        start16(1'b0, 16'h7FFF, 16'h0001);
        wait16(c);
        n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL ovf_add_result got %h exp 8000", result); end
        n_checks++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL ovf_add_cout got %b exp 0", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== {1'b0, FE, FE}) begin n_fail++; $display("FAIL ovf_add_flags got %b exp %b", {flag_z, flag_n, flag_v}, {1'b0, FE, FE}); end
        start16(1'b1, 16'h8000, 16'h0001);
        wait16(c);
        n_checks++; if (result !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sub_result got %h exp 7fff", result); end
        n_checks++; if (cout !== 1'b1)       begin n_fail++; $display("FAIL ovf_sub_cout got %b exp 1", cout); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== {1'b0, 1'b0, FE}) begin n_fail++; $display("FAIL ovf_sub_flags got %b exp %b", {flag_z, flag_n, flag_v}, {1'b0, 1'b0, FE}); end
    endtask

    task automatic test_ignore_busy;
        int c;
        start16(1'b0, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 16'h4444; b = 16'h0004;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b exp 1", busy); end
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                c = i;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (done !== 1'b1)       begin n_fail++; $display("FAIL ignore_done got %b exp 1", done); end
        n_checks++; if (result !== 16'h3333) begin n_fail++; $display("FAIL ignore_result got %h exp 3333", result); end
        n_checks++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL ignore_cout got %b exp 0", cout); end
    endtask

    task automatic test_back_to_back;
        int c;
        start16(1'b0, 16'h0F0F, 16'h0101);
        wait16(c);
        n_checks++; if (result !== 16'h1010) begin n_fail++; $display("FAIL b2b_first got %h exp 1010", result); end
        start = 1'b1; op = 1'b1; a = 16'h0300; b = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept got busy/done %b exp 10", {busy, done}); end
        wait16(c);
        n_checks++; if (c != 4)              begin n_fail++; $display("FAIL b2b_latency got %0d exp 4", c); end
        n_checks++; if (result !== 16'h0200) begin n_fail++; $display("FAIL b2b_result got %h exp 0200", result); end
        n_checks++; if (cout !== 1'b1)       begin n_fail++; $display("FAIL b2b_cout got %b exp 1", cout); end
    endtask

    task automatic test_abort;
        int c;
        bit saw_done;
        start16(1'b0, 16'h1234, 16'h1111);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, cout} !== 3'b000) begin n_fail++; $display("FAIL abort_ctrl got %b exp 000", {busy, done, cout}); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL abort_result got %h exp 0000", result); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b exp 000", {flag_z, flag_n, flag_v}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        start16(1'b0, 16'h00FF, 16'h0001);
        wait16(c);
        n_checks++; if (c != 4)              begin n_fail++; $display("FAIL abort_restart_latency got %0d exp 4", c); end
        n_checks++; if (result !== 16'h0100) begin n_fail++; $display("FAIL abort_restart_result got %h exp 0100", result); end
    endtask

    task automatic test_single_pass;
        int c;
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL sp_busy got %b exp 1", busy8); end
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                c = i;
                break;
            end
        end
        n_checks++; if (c != 1)            begin n_fail++; $display("FAIL sp_latency got %0d exp 1", c); end
        n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL sp_result got %h exp 00", result8); end
        n_checks++; if (cout8 !== 1'b1)    begin n_fail++; $display("FAIL sp_cout got %b exp 1", cout8); end
        n_checks++; if ({fz8, fn8, fv8} !== {FE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sp_flags got %b exp %b", {fz8, fn8, fv8}, {FE, 1'b0, 1'b0}); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_ignore_busy;
        test_back_to_back;
        test_abort;
        test_single_pass;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
